// File: rtl/rr_mux_select_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
//   Shared types and constants for the round-robin mux-select arbiter:
//   requester count, select width, FSM state encoding, the select index type
//   and a helper that turns a select index into a one-hot grant vector.
// ---------------------------------------------------------------------------
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_ZERO = {SEL_W{1'b0}};
  localparam sel_t SEL_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};

  // Binary select index -> one-hot grant vector
  function automatic logic [NUM_REQ-1:0] sel_to_onehot(input sel_t s);
    logic [NUM_REQ-1:0] one_v;
    one_v = {{(NUM_REQ-1){1'b0}}, 1'b1};
    return one_v << s;
  endfunction

endpackage

// File: rtl/rr_mux_select_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_mux_select_arbiter_if
//   Bundle between the requesters/mux and the arbiter.
//     req       requester -> arbiter  level request per requester
//     done      requester -> arbiter  owner releases its grant
//     grant     arbiter -> requesters one-hot grant, zero when idle
//     sel       arbiter -> mux        binary index of the owner
//     sel_valid arbiter -> mux        a grant is held, mux output meaningful
//     timeout   arbiter -> requesters pulse on a forced release
//   master: requester/mux side.  slave: arbiter side.
// ---------------------------------------------------------------------------
interface rr_mux_select_arbiter_if;
  import mux_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  sel_t               sel;
  logic               sel_valid;
  logic               timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  sel,
    input  sel_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output sel,
    output sel_valid,
    output timeout
  );

endinterface

// File: rtl/rr_mux_select_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
//   Combinational rotating priority encoder. Scans the request vector
//   starting at index 'start', wrapping from NUM_REQ-1 back to 0, and reports
//   the first set bit.
//     req    in   NUM_REQ  candidate requests
//     start  in   SEL_W    index with highest priority
//     idx    out  SEL_W    winning index (0 when nothing found)
//     found  out  1        at least one request bit was set
// ---------------------------------------------------------------------------
module rr_priority_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  sel_t               start,
  output sel_t               idx,
  output logic               found
);

  // Walk the candidates in rotated order; the index wraps naturally in SEL_W bits
  always_comb begin
    sel_t cand_v;
    idx    = SEL_ZERO;
    found  = 1'b0;
    cand_v = start;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_v = start + sel_t'(i);
      if (!found && req[cand_v]) begin
        found = 1'b1;
        idx   = cand_v;
      end else begin
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_mux_select_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_select_arbiter
//   Round-robin arbiter driving the 2-bit select of a downstream 4:1 mux.
//   Grants one of four requesters at a time; the grant is held until the
//   owner pulses done or withdraws its request, then the next requester in
//   rotation is granted on the following edge with no idle bubble.
//   Ports:
//     clk    in     single clock, rising edge
//     rst_n  in     synchronous active-low reset
//     bus    slave  rr_mux_select_arbiter_if (req, done -> grant, sel,
//                   sel_valid, timeout), all outputs registered
//   Parameter HOLD_MAX (1..255): longest a grant may be held when the
//   ARB_TIMEOUT_EN macro is defined. Without ARB_TIMEOUT_EN a grant is held
//   indefinitely and timeout stays 0.
// ---------------------------------------------------------------------------
module rr_mux_select_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  rr_mux_select_arbiter_if.slave bus
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  arb_state_t         state_r;
  logic [NUM_REQ-1:0] grant_r;
  sel_t               sel_r;
  sel_t               last_ptr_r;
  logic               sel_valid_r;
  logic               timeout_r;

  logic [NUM_REQ-1:0] pick_req_s;
  sel_t               pick_start_s;
  sel_t               pick_idx_s;
  logic               pick_found_s;
  logic               owner_req_s;
  logic               release_s;
  logic               timeout_hit_s;
  logic               forced_s;
  logic               new_grant_s;

  // Arbitration inputs: in IDLE search after the last owner; in GRANT search
  // after the current owner and leave the releasing owner out for this cycle
  always_comb begin
    pick_req_s   = bus.req;
    pick_start_s = last_ptr_r + SEL_ONE;
    if (state_r == GRANT) begin
      pick_req_s   = bus.req & ~grant_r;
      pick_start_s = sel_r + SEL_ONE;
    end else begin
      pick_req_s   = bus.req;
      pick_start_s = last_ptr_r + SEL_ONE;
    end
  end

  rr_priority_pick u_pick (
    .req   (pick_req_s),
    .start (pick_start_s),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  assign owner_req_s = bus.req[sel_r];
  assign release_s   = (state_r == GRANT) && (bus.done || !owner_req_s || timeout_hit_s);
  // Timeout is only reported when nothing else would have released the grant
  assign forced_s    = (state_r == GRANT) && timeout_hit_s && !bus.done && owner_req_s;
  assign new_grant_s = pick_found_s && ((state_r == IDLE) || release_s);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_r;

  assign timeout_hit_s = (hold_cnt_r == HOLD_LAST);

  // Hold counter: restarts with every new grant, counts cycles spent in GRANT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_r <= 8'd0;
    end else if (new_grant_s) begin
      hold_cnt_r <= 8'd0;
    end else if (state_r == GRANT) begin
      hold_cnt_r <= hold_cnt_r + 8'd1;
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end
`else
  logic unused_hold_s;

  assign timeout_hit_s = 1'b0;
  assign unused_hold_s = ^HOLD_LAST;
`endif

  // Arbiter FSM with pointer and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      grant_r     <= {NUM_REQ{1'b0}};
      sel_r       <= SEL_ZERO;
      sel_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
      last_ptr_r  <= sel_t'(NUM_REQ - 1);
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (new_grant_s) begin
            state_r     <= GRANT;
            grant_r     <= sel_to_onehot(pick_idx_s);
            sel_r       <= pick_idx_s;
            sel_valid_r <= 1'b1;
          end else begin
            state_r     <= IDLE;
          end
        end
        GRANT: begin
          if (release_s) begin
            last_ptr_r <= sel_r;
            timeout_r  <= forced_s;
            if (new_grant_s) begin
              state_r     <= GRANT;
              grant_r     <= sel_to_onehot(pick_idx_s);
              sel_r       <= pick_idx_s;
              sel_valid_r <= 1'b1;
            end else begin
              // sel keeps the last owner so the mux input stays put
              state_r     <= IDLE;
              grant_r     <= {NUM_REQ{1'b0}};
              sel_valid_r <= 1'b0;
            end
          end else begin
            state_r <= GRANT;
          end
        end
        default: begin
          state_r     <= IDLE;
          grant_r     <= {NUM_REQ{1'b0}};
          sel_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant     = grant_r;
  assign bus.sel       = sel_r;
  assign bus.sel_valid = sel_valid_r;
  assign bus.timeout   = timeout_r;

endmodule
